// File: rtl/mem_load_unit_pkg.sv
// Shared definitions for the load unit: access-size encodings, FSM state
// encoding and the request alignment check used at acceptance time.
package mem_load_unit_pkg;

  // Access size encodings carried on ld_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Load unit control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  // Returns 1 when a request cannot be issued: a half on an odd byte, a word
  // not on a 4-byte boundary, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Lane extraction and sign/zero extension of a little-endian read word.
// Purely combinational; the caller guarantees the lane is legal for the size.
module load_extract
  import mem_load_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half-word lanes out of the read word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (lane)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Widen the selected lane; words pass through regardless of uns
  always_comb begin
    data = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        if (uns) begin
          data = {24'h00_0000, byte_s};
        end else begin
          data = {{24{byte_s[7]}}, byte_s};
        end
      end
      SZ_HALF: begin
        if (uns) begin
          data = {16'h0000, half_s};
        end else begin
          data = {{16{half_s[15]}}, half_s};
        end
      end
      SZ_WORD: data = rdata;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: accepts one load, issues a word-aligned memory read with a
// req/ack handshake, extends the addressed lane and holds the result for
// writeback. One load in flight; misalignment and memory timeout are
// reported as single-cycle pulses.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [REG_W-1:0]  ld_rd,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  input  logic              wb_ready,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lsu_state_e state_r;
  lsu_state_e state_nxt_s;

  // Request attributes captured at acceptance
  logic [1:0]       size_r;
  logic [1:0]       lane_r;
  logic             uns_r;
  logic [REG_W-1:0] rd_r;
  logic [CNT_W-1:0] cnt_r;

  // Single-cycle control strobes decoded from the current state
  logic             accept_s;
  logic             issue_s;
  logic             misalign_s;
  logic             ack_s;
  logic             timeout_s;
  logic             done_s;
  logic [DATA_W-1:0] ext_data_s;

  // Requests are only taken while idle; this depends on state alone
  assign ld_ready = (state_r == ST_IDLE);

  load_extract u_extract (
    .rdata (mem_rdata),
    .lane  (lane_r),
    .size  (size_r),
    .uns   (uns_r),
    .data  (ext_data_s)
  );

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    misalign_s  = 1'b0;
    ack_s       = 1'b0;
    timeout_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ld_valid) begin
          accept_s = 1'b1;
          if (is_misaligned(ld_size, ld_addr[1:0])) begin
            misalign_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            issue_s     = 1'b1;
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An ack on the last permitted cycle still completes the load
        if (mem_ack) begin
          ack_s       = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (wb_ready) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Capture request attributes when a load is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_r <= SZ_BYTE;
      lane_r <= 2'b00;
      uns_r  <= 1'b0;
      rd_r   <= '0;
    end else if (accept_s) begin
      size_r <= ld_size;
      lane_r <= ld_addr[1:0];
      uns_r  <= ld_unsigned;
      rd_r   <= ld_rd;
    end
  end

  // Memory request, aligned address and wait-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cnt_r    <= '0;
    end else begin
      if (issue_s) begin
        mem_req  <= 1'b1;
        mem_addr <= {ld_addr[DATA_W-1:2], 2'b00};
        cnt_r    <= '0;
      end else if (ack_s || timeout_s) begin
        mem_req  <= 1'b0;
      end else if (state_r == ST_REQ) begin
        cnt_r    <= cnt_r + CNT_ONE;
      end
    end
  end

  // Writeback holding registers: loaded on ack, released on wb_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
    end else begin
      if (ack_s) begin
        wb_valid <= 1'b1;
        wb_data  <= ext_data_s;
        wb_rd    <= rd_r;
      end else if (done_s) begin
        wb_valid <= 1'b0;
      end
    end
  end

  // Error pulses, each high for exactly the cycle after the event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      misalign_err <= misalign_s;
      timeout_err  <= timeout_s;
    end
  end

endmodule
